// File: rtl/inter_switch_sched.sv
// rtl/inter_switch_sched.sv - route scheduler that sequences descriptors and drives the inter_switch ctrl word
// Optional feature macro: SCHED_TIMEOUT_EN adds a stall watchdog and the sticky timeout output.
module inter_switch_sched #(
  parameter int CMD_DEPTH = 4,
  parameter int CNT_W     = 16,
  parameter int TO_CYCLES = 65535
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [18+2*CNT_W-1:0] cmd_tdata,
  input  logic                  cmd_tvalid,
  output logic                  cmd_tready,
  input  logic [4:0]            in_fire_vec,
  input  logic [7:0]            out_fire_vec,
  output logic [17:0]           sw_ctrl,
  output logic                  busy,
  output logic                  route_done,
  output logic [15:0]           done_cnt,
  output logic                  err
`ifdef SCHED_TIMEOUT_EN
  ,
  output logic                  timeout
`endif
);
  localparam int DW = 18 + 2*CNT_W;
  localparam int AW = $clog2(CMD_DEPTH);
  localparam logic [2:0] SRC_OFF = 3'd7;
  localparam logic [CNT_W:0] ONE = (CNT_W+1)'(1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_RUN   = 2'd2;
  localparam logic [1:0] S_DRAIN = 2'd3;

  logic [DW-1:0]    mem [CMD_DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      count, count_next;
  logic [DW-1:0]    head;
  logic             push, pop;

  logic [1:0]       state;
  logic [17:0]      d_ctrl;
  logic [CNT_W-1:0] d_in, d_out, in_cnt, out_cnt;
  logic [7:0]       src_vec;
  logic             in_fire, out_fire, in_last, out_done, wd_hit, finish;

  assign push       = cmd_tvalid & cmd_tready;
  assign head       = mem[rd_ptr];
  // Source codes 5..7 select nothing, so pad the vector to the full code space.
  assign src_vec    = {3'b000, in_fire_vec};
  assign in_fire    = src_vec[d_ctrl[2:0]];
  assign out_fire   = out_fire_vec[d_ctrl[5:3]];
  assign in_last    = in_fire && (({1'b0, in_cnt} + ONE) == {1'b0, d_in});
  // out_cnt saturates at the budget, so "already there" also counts as complete.
  assign out_done   = (out_cnt == d_out) ||
                      (out_fire && (({1'b0, out_cnt} + ONE) == {1'b0, d_out}));
  assign finish     = ((state == S_DRAIN) && out_done) || wd_hit;
  assign pop        = (count != '0) && ((state == S_IDLE) || finish);
  assign count_next = count + (AW+1)'(push) - (AW+1)'(pop);

  // Descriptor storage; stale entries are harmless because the pointers define occupancy.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= cmd_tdata;
  end

  // FIFO pointers, occupancy and registered ready.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      cmd_tready <= 1'b1;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count      <= count_next;
      cmd_tready <= (count_next != (AW+1)'(CMD_DEPTH));
    end
  end

  // Route sequencer: load descriptor, run until input budget spent, drain the sink.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      busy    <= 1'b0;
      sw_ctrl <= 18'h00007;
      d_ctrl  <= 18'h00007;
      d_in    <= '0;
      d_out   <= '0;
      in_cnt  <= '0;
      out_cnt <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (pop) begin
            state <= S_LOAD;
            busy  <= 1'b1;
          end
        end
        S_LOAD: begin
          sw_ctrl <= d_ctrl;
          if (d_in == '0) begin
            sw_ctrl[2:0] <= SRC_OFF;
            state        <= S_DRAIN;
          end else begin
            state <= S_RUN;
          end
        end
        S_RUN: begin
          if (in_fire) in_cnt <= in_cnt + CNT_W'(1);
          if (out_fire && (out_cnt != d_out)) out_cnt <= out_cnt + CNT_W'(1);
          // Gate the source on the edge that accepts the last budgeted beat.
          if (in_last) begin
            sw_ctrl[2:0] <= SRC_OFF;
            state        <= S_DRAIN;
          end
        end
        default: begin
          if (out_fire && (out_cnt != d_out)) out_cnt <= out_cnt + CNT_W'(1);
        end
      endcase
      if (finish) begin
        sw_ctrl[2:0] <= SRC_OFF;
        state        <= pop ? S_LOAD : S_IDLE;
        busy         <= pop;
      end
      if (pop) begin
        d_ctrl  <= head[17:0];
        d_in    <= head[18 +: CNT_W];
        d_out   <= head[18+CNT_W +: CNT_W];
        in_cnt  <= '0;
        out_cnt <= '0;
      end
    end
  end

  // Completion pulse, completion count and sticky over-budget error.
  always_ff @(posedge clk) begin
    if (rst) begin
      route_done <= 1'b0;
      done_cnt   <= '0;
      err        <= 1'b0;
    end else begin
      route_done <= finish;
      if (finish) done_cnt <= done_cnt + 16'd1;
      if ((out_fire && (out_cnt == d_out)) || (in_fire && (sw_ctrl[2:0] == SRC_OFF)))
        err <= 1'b1;
    end
  end

`ifdef SCHED_TIMEOUT_EN
  localparam int WD_W = $clog2(TO_CYCLES + 1);
  logic [WD_W-1:0] wd_cnt;
  logic            wd_active;

  assign wd_active = ((state == S_RUN) || (state == S_DRAIN)) && !in_fire && !out_fire;
  assign wd_hit    = wd_active && (wd_cnt == WD_W'(TO_CYCLES - 1));

  // Stall watchdog: counts fire-free active cycles, forces completion at the limit.
  always_ff @(posedge clk) begin
    if (rst) begin
      wd_cnt  <= '0;
      timeout <= 1'b0;
    end else begin
      if (wd_active && !wd_hit) wd_cnt <= wd_cnt + WD_W'(1);
      else                      wd_cnt <= '0;
      if (wd_hit) timeout <= 1'b1;
    end
  end
`else
  assign wd_hit = 1'b0;
`endif

endmodule
